// File: rtl/adc_peak_window.sv
// ============================================================================
// adc_peak_window
//
// Windowed peak detector for the polyphase ADC sample stream. LANES samples
// arrive per beat; each lane keeps a running maximum (and, when built, a
// running minimum) over win_len valid beats. When a window closes, the lane
// accumulators are snapshotted and reduced through a pipelined pairwise
// comparator tree, and one result is presented with a single-cycle strobe.
//
// Optional feature macro: ADC_PEAK_MIN_EN
//   defined   -> parallel minimum accumulator, snapshot, min-tree and the
//                peak_min output port are built (same latency as max path)
//   undefined -> no minimum logic, no peak_min port
//
// Ports:
//   clk         sample clock
//   rst         asynchronous, active-high reset
//   din         LANES samples, lane m at [(m+1)*W-1 : m*W], lane 0 earliest
//   din_valid   beat qualifier
//   win_len     beats per window (0 behaves as 1), latched at window start
//   clear       synchronous abort of the current partial window
//   peak_max    window maximum, held until the next result
//   peak_min    window minimum (ADC_PEAK_MIN_EN only)
//   sat_flag    window contained at least one full-scale code
//   peak_valid  one-cycle pulse when new results are presented
//
// Latency: closing beat on din at cycle t -> peak_valid at t+3+log2(LANES).
// ============================================================================
module adc_peak_window #(
   parameter int unsigned ADC_DATA_WIDTH = 8,
   parameter int unsigned LANES          = 8,
   parameter int unsigned WIN_CNT_WIDTH  = 24,
   parameter bit          SIGNED         = 1'b0
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [ADC_DATA_WIDTH*LANES-1:0]  din,
   input  logic                             din_valid,
   input  logic [WIN_CNT_WIDTH-1:0]         win_len,
   input  logic                             clear,
   output logic [ADC_DATA_WIDTH-1:0]        peak_max,
`ifdef ADC_PEAK_MIN_EN
   output logic [ADC_DATA_WIDTH-1:0]        peak_min,
`endif
   output logic                             sat_flag,
   output logic                             peak_valid
);

   localparam int unsigned W   = ADC_DATA_WIDTH;
   localparam int unsigned LVL = $clog2(LANES);

   typedef enum logic {EMPTY, ACCUM} state_t;

   // a > b under the configured number representation
   function automatic logic gt(input logic [W-1:0] a, input logic [W-1:0] b);
      if (SIGNED) return $signed(a) > $signed(b);
      return a > b;
   endfunction

   function automatic logic full_scale(input logic [W-1:0] x);
      if (SIGNED) return (x == {1'b0, {(W-1){1'b1}}}) || (x == {1'b1, {(W-1){1'b0}}});
      return (x == '1) || (x == '0);
   endfunction

   // ------------------------------------------------------------------------
   // Stage 0: input register. clear and win_len travel with the data so that
   // a beat and a clear presented together are seen together by the FSM.
   // ------------------------------------------------------------------------
   logic [W*LANES-1:0]       din_q;
   logic                     din_vld_q;
   logic                     clear_q;
   logic [WIN_CNT_WIDTH-1:0] win_len_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         din_q     <= '0;
         din_vld_q <= 1'b0;
         clear_q   <= 1'b0;
         win_len_q <= '0;
      end else begin
         din_q     <= din;
         din_vld_q <= din_valid;
         clear_q   <= clear;
         win_len_q <= win_len;
      end
   end

   logic [W-1:0] lane_smp [LANES];

   always_comb begin
      for (int unsigned m = 0; m < LANES; m++) begin
         lane_smp[m] = din_q[m*W +: W];
      end
   end

   // ------------------------------------------------------------------------
   // Window FSM, lane accumulators and snapshot
   // ------------------------------------------------------------------------
   state_t                   state_q, state_d;
   logic [WIN_CNT_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
   logic [WIN_CNT_WIDTH-1:0] len_q, len_d;
   logic [W-1:0]             acc_max_q [LANES];
   logic [W-1:0]             acc_max_d [LANES];
   logic                     acc_sat_q, acc_sat_d;
   logic [W-1:0]             snap_max_q [LANES];
   logic [W-1:0]             snap_max_d [LANES];
   logic                     snap_sat_q, snap_sat_d;
   logic                     snap_vld_q, snap_vld_d;

   logic                     win_first;
   logic [WIN_CNT_WIDTH-1:0] len_eff;
   logic [WIN_CNT_WIDTH-1:0] cnt_inc;
   logic [W-1:0]             lane_max_nxt [LANES];
   logic                     sat_beat;
   logic                     sat_nxt;

`ifdef ADC_PEAK_MIN_EN
   logic [W-1:0]             acc_min_q [LANES];
   logic [W-1:0]             acc_min_d [LANES];
   logic [W-1:0]             snap_min_q [LANES];
   logic [W-1:0]             snap_min_d [LANES];
   logic [W-1:0]             lane_min_nxt [LANES];
`endif

   always_comb begin
      state_d    = state_q;
      beat_cnt_d = beat_cnt_q;
      len_d      = len_q;
      acc_max_d  = acc_max_q;
      acc_sat_d  = acc_sat_q;
      snap_max_d = snap_max_q;
      snap_sat_d = snap_sat_q;
      snap_vld_d = 1'b0;
`ifdef ADC_PEAK_MIN_EN
      acc_min_d  = acc_min_q;
      snap_min_d = snap_min_q;
`endif

      win_first = (state_q == EMPTY);
      len_eff   = win_first ? ((win_len_q == '0) ? WIN_CNT_WIDTH'(1) : win_len_q) : len_q;
      cnt_inc   = win_first ? WIN_CNT_WIDTH'(1) : beat_cnt_q + WIN_CNT_WIDTH'(1);

      // The first beat of a window loads the accumulators directly; later
      // beats fold into them. Computed every cycle so the snapshot can take
      // the closing beat without an extra stage.
      sat_beat = 1'b0;
      for (int unsigned m = 0; m < LANES; m++) begin
         lane_max_nxt[m] = (win_first || gt(lane_smp[m], acc_max_q[m])) ? lane_smp[m] : acc_max_q[m];
`ifdef ADC_PEAK_MIN_EN
         lane_min_nxt[m] = (win_first || gt(acc_min_q[m], lane_smp[m])) ? lane_smp[m] : acc_min_q[m];
`endif
         sat_beat = sat_beat | full_scale(lane_smp[m]);
      end
      sat_nxt = sat_beat | (~win_first & acc_sat_q);

      if (clear_q) begin
         // The beat registered alongside clear is dropped with the window.
         state_d    = EMPTY;
         beat_cnt_d = '0;
      end else if (din_vld_q) begin
         acc_max_d = lane_max_nxt;
         acc_sat_d = sat_nxt;
`ifdef ADC_PEAK_MIN_EN
         acc_min_d = lane_min_nxt;
`endif
         len_d     = len_eff;
         if (cnt_inc == len_eff) begin
            snap_max_d = lane_max_nxt;
            snap_sat_d = sat_nxt;
`ifdef ADC_PEAK_MIN_EN
            snap_min_d = lane_min_nxt;
`endif
            snap_vld_d = 1'b1;
            state_d    = EMPTY;
            beat_cnt_d = '0;
         end else begin
            state_d    = ACCUM;
            beat_cnt_d = cnt_inc;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= EMPTY;
         beat_cnt_q <= '0;
         len_q      <= '0;
         acc_max_q  <= '{default: '0};
         acc_sat_q  <= 1'b0;
         snap_max_q <= '{default: '0};
         snap_sat_q <= 1'b0;
         snap_vld_q <= 1'b0;
`ifdef ADC_PEAK_MIN_EN
         acc_min_q  <= '{default: '0};
         snap_min_q <= '{default: '0};
`endif
      end else begin
         state_q    <= state_d;
         beat_cnt_q <= beat_cnt_d;
         len_q      <= len_d;
         acc_max_q  <= acc_max_d;
         acc_sat_q  <= acc_sat_d;
         snap_max_q <= snap_max_d;
         snap_sat_q <= snap_sat_d;
         snap_vld_q <= snap_vld_d;
`ifdef ADC_PEAK_MIN_EN
         acc_min_q  <= acc_min_d;
         snap_min_q <= snap_min_d;
`endif
      end
   end

   // ------------------------------------------------------------------------
   // Comparator tree, heap-indexed: node n reduces children 2n (even lane
   // side) and 2n+1; leaves LANES..2*LANES-1 are the snapshot lanes. Every
   // internal node is a register, so each depth is one pipeline stage and
   // the root (node 1) is valid LVL cycles after the snapshot.
   // ------------------------------------------------------------------------
   logic [W-1:0]   node_max_q [1:LANES-1];
   logic [W-1:0]   node_max_d [1:LANES-1];
   logic [W-1:0]   all_max    [1:2*LANES-1];
   logic [LVL-1:0] tree_vld_q, tree_vld_d;
   logic [LVL-1:0] tree_sat_q, tree_sat_d;

`ifdef ADC_PEAK_MIN_EN
   logic [W-1:0]   node_min_q [1:LANES-1];
   logic [W-1:0]   node_min_d [1:LANES-1];
   logic [W-1:0]   all_min    [1:2*LANES-1];
`endif

   always_comb begin
      for (int unsigned n = 1; n < LANES; n++) begin
         all_max[n] = node_max_q[n];
`ifdef ADC_PEAK_MIN_EN
         all_min[n] = node_min_q[n];
`endif
      end
      for (int unsigned m = 0; m < LANES; m++) begin
         all_max[LANES+m] = snap_max_q[m];
`ifdef ADC_PEAK_MIN_EN
         all_min[LANES+m] = snap_min_q[m];
`endif
      end
      // Odd child wins only when strictly better, so ties keep the even lane.
      for (int unsigned n = 1; n < LANES; n++) begin
         node_max_d[n] = gt(all_max[2*n+1], all_max[2*n]) ? all_max[2*n+1] : all_max[2*n];
`ifdef ADC_PEAK_MIN_EN
         node_min_d[n] = gt(all_min[2*n], all_min[2*n+1]) ? all_min[2*n+1] : all_min[2*n];
`endif
      end
      tree_vld_d = LVL'({tree_vld_q, snap_vld_q});
      tree_sat_d = LVL'({tree_sat_q, snap_sat_q});
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         node_max_q <= '{default: '0};
         tree_vld_q <= '0;
         tree_sat_q <= '0;
`ifdef ADC_PEAK_MIN_EN
         node_min_q <= '{default: '0};
`endif
      end else begin
         node_max_q <= node_max_d;
         tree_vld_q <= tree_vld_d;
         tree_sat_q <= tree_sat_d;
`ifdef ADC_PEAK_MIN_EN
         node_min_q <= node_min_d;
`endif
      end
   end

   // ------------------------------------------------------------------------
   // Output register: results load only with the root valid and hold after.
   // ------------------------------------------------------------------------
   logic [W-1:0] peak_max_q, peak_max_d;
   logic         sat_flag_q, sat_flag_d;
   logic         peak_valid_q, peak_valid_d;
`ifdef ADC_PEAK_MIN_EN
   logic [W-1:0] peak_min_q, peak_min_d;
`endif

   always_comb begin
      peak_max_d   = peak_max_q;
      sat_flag_d   = sat_flag_q;
      peak_valid_d = tree_vld_q[LVL-1];
`ifdef ADC_PEAK_MIN_EN
      peak_min_d   = peak_min_q;
`endif
      if (tree_vld_q[LVL-1]) begin
         peak_max_d = node_max_q[1];
         sat_flag_d = tree_sat_q[LVL-1];
`ifdef ADC_PEAK_MIN_EN
         peak_min_d = node_min_q[1];
`endif
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         peak_max_q   <= '0;
         sat_flag_q   <= 1'b0;
         peak_valid_q <= 1'b0;
`ifdef ADC_PEAK_MIN_EN
         peak_min_q   <= '0;
`endif
      end else begin
         peak_max_q   <= peak_max_d;
         sat_flag_q   <= sat_flag_d;
         peak_valid_q <= peak_valid_d;
`ifdef ADC_PEAK_MIN_EN
         peak_min_q   <= peak_min_d;
`endif
      end
   end

   assign peak_max   = peak_max_q;
   assign sat_flag   = sat_flag_q;
   assign peak_valid = peak_valid_q;
`ifdef ADC_PEAK_MIN_EN
   assign peak_min   = peak_min_q;
`endif

endmodule

// File: doc/adc_peak_window.md
# adc_peak_window

Windowed peak detector for the polyphase ADC sample stream: accepts `LANES` parallel samples per clock, tracks a per-lane running maximum (and optionally minimum) over a programmable number of input beats, then reduces the lanes through a pipelined comparator tree. It emits one result per window with a valid strobe. It sits after the ADC interface deserialiser, next to the per-core max blocks. Unlike those blocks it has no internal millisecond timebase, it starts each new window without losing the boundary sample, and it supports signed data and a saturation flag.

## Interface
- `ADC_DATA_WIDTH`, 8, sample width in bits
- `LANES`, 8, parallel samples per beat; power of two, 2..32
- `WIN_CNT_WIDTH`, 24, width of window-length counter
- `SIGNED`, 0, 1 = two's-complement compare, 0 = unsigned compare
- `clk` in 1 — sample clock
- `rst` in 1 — asynchronous, active-high reset
- `din` in `ADC_DATA_WIDTH*LANES` — lane m at bits `[(m+1)*W-1 : m*W]`; lane 0 is the earliest phase
- `din_valid` in 1 — beat qualifier
- `win_len` in `WIN_CNT_WIDTH` — beats per window; 0 is treated as 1
- `clear` in 1 — synchronous abort of the current partial window
- `peak_max` out `ADC_DATA_WIDTH` — window maximum, held until the next result
- `peak_min` out `ADC_DATA_WIDTH` — window minimum; present only with `ADC_PEAK_MIN_EN`
- `sat_flag` out 1 — window contained at least one full-scale code
- `peak_valid` out 1 — one-cycle pulse when new results are presented

## Operation
- Stage 0: `din` and `din_valid` are registered once before any compare.
- Window FSM has two states:
  - EMPTY (reset state): the next valid beat loads each lane accumulator directly with its sample, latches `win_len` (0 becomes 1), sets `beat_cnt` to 1, and enters ACCUM. If the latched length is 1, the window also closes on that beat.
  - ACCUM: each valid beat updates `acc_max[m] = max(acc_max[m], sample[m])` and increments `beat_cnt`. The beat that makes `beat_cnt` equal the latched length closes the window.
  - On close, the lane accumulators, including the closing beat, are copied to a snapshot register with a snapshot-valid bit. The FSM returns to EMPTY, so the next beat starts a fresh window with no lost or duplicated samples.
- `win_len` changes take effect only at the next window start.
- Invalid beats (`din_valid` = 0) do not advance the counter and do not alter the accumulators.
- Compare rules:
  - `SIGNED` = 1: signed comparison. Full-scale means code 0x7F..F or 0x80..0.
  - `SIGNED` = 0: unsigned comparison. Full-scale means all-ones or zero.
  - `sat_flag` accumulates as an OR across the window, on the same schedule as `acc_max`.
- Comparator tree:
  - log2(`LANES`) levels, one register per level, pairwise max of lanes 2k+1 and 2k.
  - Ties select the even (lower) lane. The value is the same either way; the rule keeps the result deterministic.
  - The valid bit travels alongside the data.
- `clear`:
  - Forces EMPTY and zeroes `beat_cnt`, discarding the partial window.
  - A beat presented in the same cycle as `clear` is discarded.
  - Snapshots and tree stages already in flight complete and still pulse `peak_valid`.
- Outputs update only with `peak_valid` and hold otherwise.

## Timing
- Reset values: `peak_max` 0, `peak_min` 0, `sat_flag` 0, `peak_valid` 0, FSM in EMPTY, `beat_cnt` 0, all pipeline valid bits 0.
- Latency: closing beat on `din` at cycle t → `peak_valid` high at cycle t+3+log2(`LANES`). This is 6 cycles for `LANES` = 8: one input register, one accumulator/snapshot, three tree levels, one output register.
- Throughput: one window may close on every beat (`win_len` = 1), giving one result per cycle with consecutive `peak_valid` pulses.
- Asserting `rst` mid-window or mid-pipeline clears everything immediately. No partial result is emitted afterwards.

## Configuration
- `ADC_PEAK_MIN_EN` defined:
  - A parallel min accumulator, snapshot and min-tree are built with identical latency.
  - Ties select the even lane.
  - `peak_min` is a port.
- `ADC_PEAK_MIN_EN` undefined: no min logic is built and the `peak_min` port is absent.

## Test plan
- `LANES`=8, `SIGNED`=0, `win_len`=4, lane 5 of beat 3 = 0xC3, all other samples 0x10 → one `peak_valid` 6 cycles after beat 3 with `peak_max`=0xC3, `sat_flag`=0.
- Back-to-back windows, `win_len`=2, continuous valid; boundary sample 0xF0 is the first beat of window 2 → window 1 result excludes 0xF0, window 2 result = 0xF0.
- `SIGNED`=1, samples −100 (0x9C) and +5 (0x05) → `peak_max`=0x05; with `ADC_PEAK_MIN_EN`, `peak_min`=0x9C; a 0x80 sample sets `sat_flag`=1.
- `win_len`=0, four valid beats with `din_valid` gaps between them → four `peak_valid` pulses, one per beat.
- `clear` asserted after 2 of 4 beats, with a large value in those 2 beats → no result contains that value; the next result arrives 4 beats after `clear`.
- `rst` asserted 2 cycles after a window closes → no `peak_valid`; all outputs read 0 after reset.
